seg_data_drive: RTL and testbench
=================================

// Module: seg_data_drive
// PURPOSE
//  Segment-data side of the vending-machine 2-digit 7-seg display; pairs with the
//  digit-select scan driver, consuming its active-low sel bus and boot_flag.
//  Accepts a binary value (price/balance 0..99), converts it to two BCD digits with a
//  sequential shift-add-3 converter, and drives active-low segment codes for the active digit.
//  Display contents update atomically only when a conversion completes.
// PARAMETERS
//  DATA_W    7   width of value input (0..127 representable)
//  BLANK_LZ  1   1: blank tens digit when it is 0; 0: show leading zero
// PORTS
//  clk        in   1       system clock
//  rst        in   1       asynchronous reset, active-high
//  boot_flag  in   1       1 = machine powered on; 0 = display dark
//  sel        in   6       digit select from scan driver, active-low
//  value      in   DATA_W  binary value to display
//  value_vld  in   1       1-cycle strobe: value is valid
//  busy       out  1       1 while a conversion is in progress
//  seg        out  8       segment bus {dp,g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//  Reset (async, rst=1): seg=8'hFF, busy=0, tens=0, ones=0, ovf=0, converter cleared.
//  Accept: at edge N with value_vld=1 && busy=0: latch value, clear BCD shift reg, bit cnt=0, busy<=1.
//  value_vld while busy=1: ignored (dropped, no queueing); in-flight conversion unaffected.
//  Convert: edges N+1..N+7, one step per edge: add 3 to each BCD nibble >=5, then shift
//   left one bit, taking value MSB first.
//  Commit: at edge N+8: tens/ones regs <= BCD result, ovf <= (latched value > 99), busy<=0.
//   busy is high for exactly 8 cycles (N+1..N+8 sampled). New value_vld accepted at N+8 or later.
//  Overflow: value > 99 -> ovf=1; both digits show dash 8'hBF until next commit with value <= 99.
//  Digit decode (active-low): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90; dp always off.
//  Output select (seg registered, 1-cycle latency from sel/boot_flag/digit regs):
//   boot_flag=0                 -> seg=8'hFF (overrides everything)
//   sel=6'b111_110 (units)      -> ovf ? BF : code(ones)
//   sel=6'b111_101 (tens)       -> ovf ? BF : (BLANK_LZ && tens==0) ? FF : code(tens)
//   any other sel (111_111, multi-low, unused digits) -> 8'hFF
//  boot_flag does not gate conversion; values accepted while dark are shown once boot_flag=1.
//  Reset mid-conversion: conversion aborted, busy=0, digits return to 0, nothing committed.
//  Simultaneous commit and sel change: seg at N+9 reflects new digits for sel sampled at N+8.
//  Display value persists indefinitely until next accepted conversion.
// TESTING
//  1 rst=1 -> seg=FF, busy=0; release, boot_flag=1, sel=111110 -> seg=C0 one clk later.
//  2 value=57 strobe -> busy=1 for 8 clks; then sel=111110 -> seg=F8, sel=111101 -> seg=92.
//  3 value=7: BLANK_LZ=1 tens slot seg=FF, units F8; BLANK_LZ=0 tens slot seg=C0.
//  4 value=120 -> after commit both slots seg=BF; then value=99 -> both slots seg=90.
//  5 value=42 strobe, value=99 strobe 3 clks later -> second dropped; display 42 (99/A4), busy low.
//  6 boot_flag=0 with any sel -> seg=FF; rst pulse mid-conversion -> busy=0, seg=FF, later units=C0.

Source files
------------

// File: rtl/seg_data_drive.sv
// Segment-data driver for the 2-digit vending display: converts a binary value
// to BCD with a shift-add-3 sequencer and drives active-low segments per digit.
module seg_data_drive #(
    parameter int DATA_W   = 7,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot_flag,
    input  logic [5:0]        sel,
    input  logic [DATA_W-1:0] value,
    input  logic              value_vld,
    output logic              busy,
    output logic [7:0]        seg
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [5:0] SEL_ONES = 6'b111110;
    localparam logic [5:0] SEL_TENS = 6'b111101;
    localparam logic [7:0] SEG_OFF  = 8'hFF;
    localparam logic [7:0] SEG_DASH = 8'hBF;

    typedef enum logic {
        S_IDLE,
        S_CONV
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_shift, w_shift_nxt;
    logic [8:0]        r_bcd, w_bcd_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_big, w_big_nxt;
    logic [3:0]        r_tens, w_tens_nxt;
    logic [3:0]        r_ones, w_ones_nxt;
    logic              r_ovf, w_ovf_nxt;
    logic [7:0]        r_seg, w_seg_nxt;

    logic [3:0]        w_adj_t;
    logic [3:0]        w_adj_o;
    logic              w_last;
    logic              w_accept;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] c;
        case (d)
            4'd0:    c = 8'hC0;
            4'd1:    c = 8'hF9;
            4'd2:    c = 8'hA4;
            4'd3:    c = 8'hB0;
            4'd4:    c = 8'h99;
            4'd5:    c = 8'h92;
            4'd6:    c = 8'h82;
            4'd7:    c = 8'hF8;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h90;
            default: c = SEG_OFF;
        endcase
        return c;
    endfunction

    assign w_adj_o = (r_bcd[3:0] >= 4'd5) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0];
    assign w_adj_t = (r_bcd[7:4] >= 4'd5) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4];

    // Commit edge also frees the converter, so a strobe there is taken.
    assign w_last   = (r_state == S_CONV) && (r_cnt == CNT_W'(DATA_W));
    assign w_accept = value_vld && ((r_state == S_IDLE) || w_last);

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_bcd_nxt   = r_bcd;
        w_cnt_nxt   = r_cnt;
        w_big_nxt   = r_big;
        w_tens_nxt  = r_tens;
        w_ones_nxt  = r_ones;
        w_ovf_nxt   = r_ovf;

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_IDLE;
            end
            S_CONV: begin
                if (w_last) begin
                    w_tens_nxt  = r_bcd[7:4];
                    w_ones_nxt  = r_bcd[3:0];
                    w_ovf_nxt   = r_big | r_bcd[8];
                    w_state_nxt = S_IDLE;
                end else begin
                    w_bcd_nxt   = {w_adj_t, w_adj_o, r_shift[DATA_W-1]};
                    w_shift_nxt = r_shift << 1;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_accept) begin
            w_shift_nxt = value;
            w_bcd_nxt   = '0;
            w_cnt_nxt   = '0;
            w_big_nxt   = (value > DATA_W'(99));
            w_state_nxt = S_CONV;
        end
    end

    always_comb begin
        w_seg_nxt = SEG_OFF;
        if (boot_flag) begin
            case (sel)
                SEL_ONES: begin
                    w_seg_nxt = r_ovf ? SEG_DASH : seg_code(r_ones);
                end
                SEL_TENS: begin
                    if (r_ovf)
                        w_seg_nxt = SEG_DASH;
                    else if (BLANK_LZ && (r_tens == 4'd0))
                        w_seg_nxt = SEG_OFF;
                    else
                        w_seg_nxt = seg_code(r_tens);
                end
                default: begin
                    w_seg_nxt = SEG_OFF;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_big   <= 1'b0;
            r_tens  <= '0;
            r_ones  <= '0;
            r_ovf   <= 1'b0;
            r_seg   <= SEG_OFF;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_bcd   <= w_bcd_nxt;
            r_cnt   <= w_cnt_nxt;
            r_big   <= w_big_nxt;
            r_tens  <= w_tens_nxt;
            r_ones  <= w_ones_nxt;
            r_ovf   <= w_ovf_nxt;
            r_seg   <= w_seg_nxt;
        end
    end

    assign busy = (r_state == S_CONV);
    assign seg  = r_seg;

endmodule

// File: tb/tb_seg_data_drive.sv
// Directed bench for seg_data_drive: one instance blanks the leading zero,
// the other shows it.
module tb_seg_data_drive;

    logic       clk;
    logic       rst;
    logic       boot_flag;
    logic [5:0] sel;
    logic [6:0] value;
    logic       value_vld;
    logic       busy1, busy0;
    logic [7:0] seg1, seg0;

    int total = 0;
    int bad   = 0;

    localparam logic [5:0] S_ONES = 6'b111110;
    localparam logic [5:0] S_TENS = 6'b111101;

    typedef struct {
        int         v;
        logic [7:0] u;
        logic [7:0] t1;
        logic [7:0] t0;
    } vec_t;

    vec_t vecs [12];

    seg_data_drive #(.DATA_W(7), .BLANK_LZ(1'b1)) u_lz (
        .clk(clk), .rst(rst), .boot_flag(boot_flag), .sel(sel),
        .value(value), .value_vld(value_vld), .busy(busy1), .seg(seg1)
    );

    seg_data_drive #(.DATA_W(7), .BLANK_LZ(1'b0)) u_zero (
        .clk(clk), .rst(rst), .boot_flag(boot_flag), .sel(sel),
        .value(value), .value_vld(value_vld), .busy(busy0), .seg(seg0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy1 && k < 20) begin
            k++;
            step();
        end
        chk(name, k, 8);
    endtask

    task automatic convert(input int v);
        value     = 7'(v);
        value_vld = 1'b1;
        step();
        value_vld = 1'b0;
        wait_idle("busy_len");
    endtask

    task automatic show(input logic [5:0] s);
        sel = s;
        step();
    endtask

    initial begin
        vecs[0]  = '{57,  8'hF8, 8'h92, 8'h92};
        vecs[1]  = '{7,   8'hF8, 8'hFF, 8'hC0};
        vecs[2]  = '{120, 8'hBF, 8'hBF, 8'hBF};
        vecs[3]  = '{99,  8'h90, 8'h90, 8'h90};
        vecs[4]  = '{0,   8'hC0, 8'hFF, 8'hC0};
        vecs[5]  = '{10,  8'hC0, 8'hF9, 8'hF9};
        vecs[6]  = '{63,  8'hB0, 8'h82, 8'h82};
        vecs[7]  = '{85,  8'h92, 8'h80, 8'h80};
        vecs[8]  = '{34,  8'h99, 8'hB0, 8'hB0};
        vecs[9]  = '{127, 8'hBF, 8'hBF, 8'hBF};
        vecs[10] = '{100, 8'hBF, 8'hBF, 8'hBF};
        vecs[11] = '{26,  8'h82, 8'hA4, 8'hA4};

        rst       = 1'b1;
        boot_flag = 1'b0;
        sel       = 6'b111111;
        value     = '0;
        value_vld = 1'b0;
        #3;
        chk("rst_seg", seg1, 8'hFF);
        chk("rst_busy", busy1, 0);
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        boot_flag = 1'b1;
        show(S_ONES);
        chk("boot_ones", seg1, 8'hC0);

        for (int i = 0; i < 12; i++) begin
            convert(vecs[i].v);
            show(S_ONES);
            chk($sformatf("ones_%0d", vecs[i].v), seg1, vecs[i].u);
            chk($sformatf("ones0_%0d", vecs[i].v), seg0, vecs[i].u);
            show(S_TENS);
            chk($sformatf("tens_lz_%0d", vecs[i].v), seg1, vecs[i].t1);
            chk($sformatf("tens_nz_%0d", vecs[i].v), seg0, vecs[i].t0);
        end

        value     = 7'd42;
        value_vld = 1'b1;
        step();
        value_vld = 1'b0;
        step();
        step();
        value     = 7'd99;
        value_vld = 1'b1;
        step();
        value_vld = 1'b0;
        begin
            int k;
            k = 0;
            while (busy1 && k < 20) begin
                k++;
                step();
            end
            chk("drop_len", k, 5);
        end
        chk("drop_busy", busy1, 0);
        show(S_ONES);
        chk("drop_ones", seg1, 8'hA4);
        show(S_TENS);
        chk("drop_tens", seg1, 8'h99);

        value     = 7'd11;
        value_vld = 1'b1;
        step();
        value_vld = 1'b0;
        repeat (7) step();
        value     = 7'd33;
        value_vld = 1'b1;
        step();
        value_vld = 1'b0;
        chk("b2b_busy", busy1, 1);
        wait_idle("b2b_len");
        show(S_ONES);
        chk("b2b_ones", seg1, 8'hB0);
        show(S_TENS);
        chk("b2b_tens", seg1, 8'hB0);

        boot_flag = 1'b0;
        show(S_ONES);
        chk("dark_ones", seg1, 8'hFF);
        show(S_TENS);
        chk("dark_tens", seg0, 8'hFF);
        boot_flag = 1'b1;
        show(6'b111100);
        chk("sel_multi", seg1, 8'hFF);
        show(6'b011111);
        chk("sel_unused", seg1, 8'hFF);
        show(6'b111111);
        chk("sel_none", seg1, 8'hFF);

        value     = 7'd57;
        value_vld = 1'b1;
        step();
        value_vld = 1'b0;
        repeat (3) step();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy1, 0);
        chk("mid_rst_seg", seg1, 8'hFF);
        step();
        rst = 1'b0;
        show(S_ONES);
        chk("post_rst_ones", seg1, 8'hC0);
        show(S_TENS);
        chk("post_rst_tens_lz", seg1, 8'hFF);
        chk("post_rst_tens_nz", seg0, 8'hC0);
        repeat (10) step();
        chk("post_rst_idle", busy1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
